// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle CPU: boot loader port, registered read-first RAM,
// and optional memory-mapped I/O at the top of the address space (enabled by MEM_MMIO_EN).
module mem_responder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              we_mem,
  output logic [WIDTH-1:0]  rdata,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [WIDTH-1:0]  ld_data,
  input  logic              ld_last,
  output logic              cpu_reset,
  output logic              running,
  input  logic [WIDTH-1:0]  io_in,
  output logic [WIDTH-1:0]  io_out
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              ld_beat;
  logic              cpu_wr;
  logic              mmio_sel;
  logic [WIDTH-1:0]  rd_word;

`ifdef MEM_MMIO_EN
  localparam logic [ADDR_W-1:0] ADDR_OUT = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_IN  = {ADDR_W{1'b1}} - ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_CYC = {ADDR_W{1'b1}} - ADDR_W'(2);

  logic [WIDTH-1:0] io_out_q;
  logic [WIDTH-1:0] cyc_cnt;
  logic [WIDTH-1:0] in_sync1;
  logic [WIDTH-1:0] in_sync2;

  assign mmio_sel = (addr == ADDR_OUT) || (addr == ADDR_IN) || (addr == ADDR_CYC);

  // MMIO registers shadow the RAM at their addresses for CPU reads
  always_comb begin
    rd_word = mem[addr];
    if (addr == ADDR_OUT) begin
      rd_word = io_out_q;
    end else if (addr == ADDR_IN) begin
      rd_word = in_sync2;
    end else if (addr == ADDR_CYC) begin
      rd_word = cyc_cnt;
    end
  end

  // Output port, input synchronizer and free-running RUN cycle counter (write clears)
  always_ff @(posedge clk) begin
    if (reset) begin
      io_out_q <= '0;
      cyc_cnt  <= '0;
      in_sync1 <= '0;
      in_sync2 <= '0;
    end else begin
      in_sync1 <= io_in;
      in_sync2 <= in_sync1;
      if (state == RUN && we_mem && addr == ADDR_OUT) begin
        io_out_q <= wdata;
      end
      if (state == RUN) begin
        if (we_mem && addr == ADDR_CYC) begin
          cyc_cnt <= '0;
        end else begin
          cyc_cnt <= cyc_cnt + WIDTH'(1);
        end
      end
    end
  end

  assign io_out = io_out_q;
`else
  logic unused_io_in;

  assign mmio_sel     = 1'b0;
  assign rd_word      = mem[addr];
  assign io_out       = '0;
  assign unused_io_in = ^io_in;
`endif

  // Writes are dropped in the reset cycle so a mid-run reset cannot corrupt the program
  assign ld_beat = (state == BOOT) && ld_valid && ld_ready && !reset;
  assign cpu_wr  = (state == RUN) && we_mem && !mmio_sel && !reset;

  // RAM keeps its contents across reset
  always_ff @(posedge clk) begin
    if (ld_beat) begin
      mem[ld_addr] <= ld_data;
    end else if (cpu_wr) begin
      mem[addr] <= wdata;
    end
  end

  // Boot/run sequencing; status outputs follow the state one cycle later
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= BOOT;
      rdata     <= '0;
      cpu_reset <= 1'b1;
      ld_ready  <= 1'b1;
      running   <= 1'b0;
    end else begin
      rdata     <= rd_word;
      cpu_reset <= (state == BOOT);
      ld_ready  <= (state == BOOT);
      running   <= (state == RUN);
      if (ld_beat && ld_last) begin
        state <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_mem_responder;

  localparam int unsigned W     = 16;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 256;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] addr;
  logic [W-1:0]  wdata;
  logic          we_mem;
  logic [W-1:0]  rdata;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [W-1:0]  ld_data;
  logic          ld_last;
  logic          cpu_reset;
  logic          running;
  logic [W-1:0]  io_in;
  logic [W-1:0]  io_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_responder #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we_mem(we_mem), .rdata(rdata),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_last(ld_last), .cpu_reset(cpu_reset), .running(running), .io_in(io_in), .io_out(io_out)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit           m_seen_reset = 0;
  bit           m_run;
  logic [W-1:0] m_mem   [DEPTH];
  bit           m_known [DEPTH];
  logic [W-1:0] m_cyc, m_s1, m_s2;
  logic [W-1:0] e_rdata, e_io_out;
  bit           e_rdata_known, e_cpu_reset, e_ld_ready, e_running;

  function automatic bit is_mmio(input logic [AW-1:0] a);
`ifdef MEM_MMIO_EN
    return a >= AW'(DEPTH - 3);
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_seen_reset  = 1;
      m_run         = 0;
      e_rdata       = '0;
      e_rdata_known = 1;
      e_cpu_reset   = 1;
      e_ld_ready    = 1;
      e_running     = 0;
      e_io_out      = '0;
      m_cyc         = '0;
      m_s1          = '0;
      m_s2          = '0;
    end else begin
      e_cpu_reset = !m_run;
      e_ld_ready  = !m_run;
      e_running   = m_run;
      // read sees values from before this edge
      if (is_mmio(addr)) begin
        e_rdata_known = 1;
        if (addr == AW'(DEPTH - 1))      e_rdata = e_io_out;
        else if (addr == AW'(DEPTH - 2)) e_rdata = m_s2;
        else                             e_rdata = m_cyc;
      end else begin
        e_rdata_known = m_known[addr];
        e_rdata       = m_mem[addr];
      end
`ifdef MEM_MMIO_EN
      if (m_run && we_mem && addr == AW'(DEPTH - 3)) m_cyc = '0;
      else if (m_run)                                m_cyc = m_cyc + 1'b1;
      if (m_run && we_mem && addr == AW'(DEPTH - 1)) e_io_out = wdata;
      m_s2 = m_s1;
      m_s1 = io_in;
`endif
      if (m_run) begin
        if (we_mem && !is_mmio(addr)) begin
          m_mem[addr]   = wdata;
          m_known[addr] = 1;
        end
      end else if (ld_valid) begin
        m_mem[ld_addr]   = ld_data;
        m_known[ld_addr] = 1;
        if (ld_last) m_run = 1;
      end
    end
  end

  // compare every cycle once the model is defined
  always @(negedge clk) begin
    if (m_seen_reset) begin
      chk("cmp_cpu_reset", W'(cpu_reset), W'(e_cpu_reset));
      chk("cmp_ld_ready", W'(ld_ready), W'(e_ld_ready));
      chk("cmp_running", W'(running), W'(e_running));
      chk("cmp_io_out", io_out, e_io_out);
      if (e_rdata_known) chk("cmp_rdata", rdata, e_rdata);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [AW-1:0] a, input logic [W-1:0] d, input logic last);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    ld_last  = last;
    cyc();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; addr = '0; wdata = '0; we_mem = 1'b0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_last = 1'b0; io_in = '0;
    cyc();
    cyc();
    chk("rst_cpu_reset", W'(cpu_reset), 16'h1);
    chk("rst_ld_ready", W'(ld_ready), 16'h1);
    chk("rst_running", W'(running), 16'h0);
    chk("rst_rdata", rdata, 16'h0);
    chk("rst_io_out", io_out, 16'h0);
    reset = 1'b0;

    // three-beat program load
    beat(8'h10, 16'h1234, 1'b0);
    beat(8'h11, 16'hABCD, 1'b0);
    beat(8'h12, 16'h0F0F, 1'b1);
    addr = 8'h11;
    chk("lag_cpu_reset", W'(cpu_reset), 16'h1);
    cyc();
    chk("run_cpu_reset", W'(cpu_reset), 16'h0);
    chk("run_ld_ready", W'(ld_ready), 16'h0);
    chk("run_running", W'(running), 16'h1);
    chk("load_rd_0x11", rdata, 16'hABCD);

    // read-during-write returns old word
    we_mem = 1'b1; addr = 8'h20; wdata = 16'h1111;
    cyc();
    wdata = 16'h5555;
    cyc();
    chk("rdw_old", rdata, 16'h1111);
    we_mem = 1'b0;
    cyc();
    chk("rdw_new", rdata, 16'h5555);
    we_mem = 1'b1; addr = 8'h30; wdata = 16'h0303;
    cyc();
    we_mem = 1'b0;

`ifdef MEM_MMIO_EN
    we_mem = 1'b1; addr = 8'hFF; wdata = 16'hBEEF;
    cyc();
    we_mem = 1'b0;
    chk("mmio_io_out", io_out, 16'hBEEF);
    cyc();
    chk("mmio_rd_out", rdata, 16'hBEEF);
    io_in = 16'h00A5; addr = 8'hFE;
    cyc();
    cyc();
    cyc();
    chk("mmio_io_in", rdata, 16'h00A5);
    we_mem = 1'b1; addr = 8'hFD;
    cyc();
    we_mem = 1'b0;
    cyc();
    chk("mmio_cyc0", rdata, 16'h0000);
    cyc();
    chk("mmio_cyc1", rdata, 16'h0001);
    cyc();
    chk("mmio_cyc2", rdata, 16'h0002);
`else
    we_mem = 1'b1; addr = 8'hFF; wdata = 16'hBEEF;
    cyc();
    we_mem = 1'b0;
    cyc();
    chk("ram_rd_0xff", rdata, 16'hBEEF);
    chk("ram_io_out", io_out, 16'h0000);
`endif

    // reset mid-run with a write in the same cycle
    reset = 1'b1; we_mem = 1'b1; addr = 8'h20; wdata = 16'hDEAD;
    cyc();
    chk("mid_cpu_reset", W'(cpu_reset), 16'h1);
    chk("mid_running", W'(running), 16'h0);
    chk("mid_ld_ready", W'(ld_ready), 16'h1);
    chk("mid_io_out", io_out, 16'h0000);
    reset = 1'b0;

    // BOOT ignores CPU writes and ld_last without ld_valid
    we_mem = 1'b1; addr = 8'h30; wdata = 16'hFFFF; ld_last = 1'b1;
    cyc();
    cyc();
    we_mem = 1'b0;
    cyc();
    chk("boot_nowrite", rdata, 16'h0303);
    chk("boot_stay", W'(cpu_reset), 16'h1);
    ld_last = 1'b0; addr = 8'h20;
    cyc();
    chk("mid_nowrite", rdata, 16'h5555);
    addr = 8'h11;
    cyc();
    chk("persist_0x11", rdata, 16'hABCD);

    // randomized traffic, including resets during load and run
    for (int n = 0; n < 4000; n++) begin
      reset    = ($urandom_range(0, 99) == 0);
      ld_valid = $urandom_range(0, 1) == 1;
      ld_last  = ($urandom_range(0, 15) == 0);
      ld_addr  = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15)) : AW'($urandom);
      ld_data  = W'($urandom);
      we_mem   = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0:       addr = AW'(DEPTH - 4 + $urandom_range(0, 3));
        1:       addr = AW'($urandom_range(0, 15));
        default: addr = AW'($urandom);
      endcase
      wdata = W'($urandom);
      if ($urandom_range(0, 3) == 0) io_in = W'($urandom);
      cyc();
    end

    reset = 1'b0; we_mem = 1'b0; ld_valid = 1'b0;
    cyc();
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle CPU's single memory port.
- Serves instruction fetches, loads and stores issued by the CPU controller.
- Has a host loader port that preloads the program while the CPU is held in reset.
- Optionally decodes memory-mapped I/O at the top of the address space.

Parameters:
WIDTH, 16, data word width (bits)
ADDR_W, 8, address width; RAM depth is 2**ADDR_W words

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
addr  input  ADDR_W  CPU memory address (address mux output)
wdata  input  WIDTH  CPU store data
we_mem  input  1  CPU write enable
rdata  output  WIDTH  registered read data to the instruction register and MDR
ld_valid  input  1  loader word valid
ld_ready  output  1  loader may transfer
ld_addr  input  ADDR_W  loader write address
ld_data  input  WIDTH  loader write data
ld_last  input  1  qualifies the final loader word
cpu_reset  output  1  hold reset for the CPU (controller and datapath)
running  output  1  high in RUN state
io_in  input  WIDTH  external input port, asynchronous to clk
io_out  output  WIDTH  external output port register

Behaviour:
- One clock (clk); reset is synchronous and active-high on port reset.
- Reset values: state=BOOT, rdata=0, cpu_reset=1, ld_ready=1, running=0, io_out=0, cycle counter=0, io_in sync flops=0.
- RAM contents are not reset and are preserved across reset.
- States: BOOT and RUN.
- BOOT:
  - cpu_reset=1, ld_ready=1; we_mem is ignored.
  - A loader beat (ld_valid & ld_ready) writes RAM[ld_addr] <= ld_data at the clock edge.
  - Beat with ld_last=1: the word is written and the next state is RUN.
  - ld_last without ld_valid is ignored.
  - Zero-length load is not supported; at least one beat is required.
- RUN:
  - cpu_reset=0, ld_ready=0, running=1. Outputs are registered, so they change the cycle after the transition.
  - ld_* inputs are ignored.
  - RUN is exited only by reset.
- Read: rdata <= RAM[addr] every cycle in both states, a 1-cycle registered read.
  - The CPU holds addr for two cycles (fetch/fetch2, load/load2), so data is valid in the second cycle.
- Write (RUN only): we_mem=1 writes RAM[addr] <= wdata at the edge.
- Read-during-write to the same address returns the OLD word (read-first); the new word is visible on the next cycle.
- Reset asserted mid-RUN: the next edge returns to BOOT, cpu_reset=1, any write in that cycle is suppressed, and io_out=0.
- Reset asserted mid-load: the loader restarts, and words already written persist.
- Address arithmetic is unsigned; there is no wrap logic beyond the natural ADDR_W width.

Optional Feature:
MEM_MMIO_EN
- Defined:
  - addr = 2**ADDR_W-1 (OUT): CPU writes update io_out; reads return io_out.
  - addr = 2**ADDR_W-2 (IN): reads return io_in through a 2-flop synchronizer, giving 2 cycles of input latency plus the 1-cycle read. Writes are ignored.
  - addr = 2**ADDR_W-3 (CYC): a WIDTH-bit counter that increments each RUN cycle and wraps at 2**WIDTH-1 to 0. Reads return its value; a CPU write clears it to 0, and the clear takes priority over the increment.
  - MMIO addresses never access RAM from the CPU side. Loader writes to these addresses go to RAM only.
- Not defined: all addresses are plain RAM, io_out is tied to 0, io_in is unused, and there is no counter.

Test Plan:
- Reset, then load 3 beats (0x10=0x1234, 0x11=0xABCD, 0x12=0x0F0F, last on the third): cpu_reset falls 1 cycle after the last beat, ld_ready=0, and reading 0x11 gives rdata=0xABCD one cycle later.
- In RUN, we_mem=1 addr=0x20 wdata=0x5555 while RAM[0x20]=0x1111: rdata=0x1111 in the write cycle (read-first) and 0x5555 in the next cycle.
- In BOOT, we_mem=1 addr=0x30 wdata=0xFFFF: RAM[0x30] is unchanged. ld_last=1 with ld_valid=0: the block stays in BOOT.
- Reset mid-RUN with we_mem=1 in the same cycle: no write, state=BOOT, cpu_reset=1, and previously loaded words are still readable.
- With MEM_MMIO_EN:
  - Write 0xBEEF to 0xFF: io_out=0xBEEF.
  - io_in=0x00A5: reading 0xFE returns 0x00A5 by the third cycle after the io_in change.
  - Write to 0xFD: the counter reads 0, then increments by 1 per cycle.
- Without MEM_MMIO_EN: write 0xBEEF to 0xFF, then read 0xFF: rdata=0xBEEF and io_out stays 0.
